// File: rtl/seven_seg_pkg.sv
// Shared definitions for the three-digit seven-segment scan driver:
// digit count, active-low glyph patterns and the digit-slot index type.
package seven_seg_pkg;

    localparam int NUM_DIGITS = 3;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    // Which digit currently owns the display
    typedef enum logic [1:0] {
        DIGIT_ONES     = 2'd0,
        DIGIT_TENS     = 2'd1,
        DIGIT_HUNDREDS = 2'd2
    } digit_idx_t;

endpackage

// File: rtl/bcd_digit_to_seg.sv
// Combinational BCD nibble to active-low seven-segment glyph.
// Any nibble outside 0..9 is shown as a dash so bad data is visible.
module bcd_digit_to_seg
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    // Glyph lookup; non-decimal codes fall through to the dash
    always_comb begin
        seg_n = SEG_DASH;
        case (nibble)
            4'd0:    seg_n = SEG_0;
            4'd1:    seg_n = SEG_1;
            4'd2:    seg_n = SEG_2;
            4'd3:    seg_n = SEG_3;
            4'd4:    seg_n = SEG_4;
            4'd5:    seg_n = SEG_5;
            4'd6:    seg_n = SEG_6;
            4'd7:    seg_n = SEG_7;
            4'd8:    seg_n = SEG_8;
            4'd9:    seg_n = SEG_9;
            default: seg_n = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed driver for a 3-digit common-anode display.
// A prescaler divides each digit slot; new BCD words are held pending and
// only copied to the display register at the frame boundary so a frame is
// never torn. Each slot begins with a dead time to suppress ghosting.
module seven_seg_scan_driver
    import seven_seg_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int DEAD_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [11:0]           bcd_in,
    input  logic                  bcd_load,
    input  logic                  blank_lz,
    output logic [NUM_DIGITS-1:0] an_n,
    output logic [6:0]            seg_n,
    output logic                  frame_start
);

    localparam int PCNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PCNT_W-1:0] PCNT_MAX = PCNT_W'(REFRESH_DIV - 1);
    localparam logic [PCNT_W-1:0] DEAD_LIM = PCNT_W'(DEAD_CYCLES);

    logic [PCNT_W-1:0]     pcnt;
    digit_idx_t            idx;
    digit_idx_t            idx_next;
    logic [11:0]           disp;
    logic [11:0]           pend;
    logic                  pend_v;
    logic                  slot_end;
    logic                  boundary;
    logic [6:0]            glyph_ones;
    logic [6:0]            glyph_tens;
    logic [6:0]            glyph_hund;
    logic                  blank_hund;
    logic                  blank_tens;
    logic [NUM_DIGITS-1:0] an_next;
    logic [6:0]            seg_next;

    assign slot_end = (pcnt == PCNT_MAX);
    assign boundary = slot_end && (idx == DIGIT_HUNDREDS);

    // Digit sequence ones -> tens -> hundreds -> ones
    always_comb begin
        idx_next = DIGIT_ONES;
        case (idx)
            DIGIT_ONES:     idx_next = DIGIT_TENS;
            DIGIT_TENS:     idx_next = DIGIT_HUNDREDS;
            default:        idx_next = DIGIT_ONES;
        endcase
    end

    // Prescaler and digit index; the index steps when a slot expires
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt <= '0;
            idx  <= DIGIT_ONES;
        end else if (slot_end) begin
            pcnt <= '0;
            idx  <= idx_next;
        end else begin
            pcnt <= pcnt + 1'b1;
        end
    end

    // Pending/display capture: loads wait in pend until the frame boundary,
    // except a load landing on the boundary itself goes straight to disp
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend   <= '0;
            pend_v <= 1'b0;
            disp   <= '0;
        end else if (boundary) begin
            if (bcd_load) begin
                disp <= bcd_in;
            end else if (pend_v) begin
                disp <= pend;
            end
            pend_v <= 1'b0;
        end else if (bcd_load) begin
            pend   <= bcd_in;
            pend_v <= 1'b1;
        end
    end

    bcd_digit_to_seg u_ones (.nibble(disp[3:0]),  .seg_n(glyph_ones));
    bcd_digit_to_seg u_tens (.nibble(disp[7:4]),  .seg_n(glyph_tens));
    bcd_digit_to_seg u_hund (.nibble(disp[11:8]), .seg_n(glyph_hund));

    // Leading-zero blanking only treats a true 0 nibble as zero
    assign blank_hund = blank_lz && (disp[11:8] == 4'd0);
    assign blank_tens = blank_hund && (disp[7:4] == 4'd0);

    // Next anode/segment pattern: dark during dead time, else the active digit
    always_comb begin
        an_next  = '1;
        seg_next = SEG_OFF;
        if (pcnt >= DEAD_LIM) begin
            case (idx)
                DIGIT_ONES: begin
                    an_next  = 3'b110;
                    seg_next = glyph_ones;
                end
                DIGIT_TENS: begin
                    an_next  = 3'b101;
                    seg_next = blank_tens ? SEG_OFF : glyph_tens;
                end
                DIGIT_HUNDREDS: begin
                    an_next  = 3'b011;
                    seg_next = blank_hund ? SEG_OFF : glyph_hund;
                end
                default: begin
                    an_next  = '1;
                    seg_next = SEG_OFF;
                end
            endcase
        end
    end

    // Registered outputs so the pins are glitch-free; frame_start marks the
    // cycle after the display register was refreshed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_n        <= '1;
            seg_n       <= SEG_OFF;
            frame_start <= 1'b0;
        end else begin
            an_n        <= an_next;
            seg_n       <= seg_next;
            frame_start <= boundary;
        end
    end

endmodule

// File: doc/seven_seg_scan_driver.md
# seven_seg_scan_driver

- Time-multiplexed driver for a 3-digit common-anode seven-segment display.
- Sits directly downstream of the binary-to-BCD converter: takes its 12-bit packed BCD word and scans one digit at a time.
- Provides tear-free frame-synchronous updates, optional leading-zero blanking, inter-digit dead time against ghosting, and a dash glyph for non-decimal nibbles.

## Interface
- `REFRESH_DIV`, default 50000: clock cycles per digit slot; legal range ≥ `DEAD_CYCLES`+1.
- `DEAD_CYCLES`, default 2: cycles at the start of each slot with all anodes off; legal range ≥ 0.
- `clk`, input, 1: the only clock; all state changes on its rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `bcd_in`, input, 12: packed BCD; `[3:0]` ones, `[7:4]` tens, `[11:8]` hundreds.
- `bcd_load`, input, 1: one-cycle strobe; captures `bcd_in`.
- `blank_lz`, input, 1: 1 = blank leading zeros.
- `an_n`, output, 3: active-low anode enables; bit i = digit i, 0 = ones.
- `seg_n`, output, 7: active-low segments `{g,f,e,d,c,b,a}`.
- `frame_start`, output, 1: one-cycle pulse when the display register is refreshed (digit index wraps to 0).

## Operation
- **Prescaler** `pcnt` counts 0..`REFRESH_DIV`-1 and wraps. On the wrap edge, digit index `idx` advances 0→1→2→0.
- **Capture registers:**
  - `bcd_load`=1 writes `bcd_in` into `pend` and sets `pend_v`. The last load before a frame boundary wins.
  - Frame boundary = the edge on which `idx` goes 2→0. At that edge, if `pend_v`, `disp`←`pend` and `pend_v` is cleared.
  - If `bcd_load` coincides with the boundary, `bcd_in` goes straight into `disp` and `pend_v` is cleared.
- **Glyphs** (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Nibble >9 displays dash 0111111.
  - Blank = 1111111.
- **Leading-zero blanking** (when `blank_lz`=1), evaluated on `disp`:
  - Hundreds is blank if its nibble is 0.
  - Tens is blank if hundreds and tens are both 0.
  - Ones is never blanked.
  - A nibble >9 is never treated as zero.
- **Dead time:** while `pcnt` < `DEAD_CYCLES`, `an_n`=111 and `seg_n`=1111111. Otherwise `an_n` has only bit `idx` low, and `seg_n` shows the glyph of digit `idx`.
- **Reset values:**
  - Outputs: `an_n`=111, `seg_n`=1111111, `frame_start`=0.
  - Internal state: `pcnt`=0, `idx`=0, `disp`=000, `pend`=000, `pend_v`=0.

## Timing
- `an_n`, `seg_n` and `frame_start` are registered. Their value in cycle t reflects `pcnt`/`idx`/`disp` of cycle t-1.
- First cycle after reset release: outputs are still at reset values. Outputs follow the rule above from the second cycle.
- `frame_start` is high in exactly the one cycle following the boundary edge, once per 3·`REFRESH_DIV` cycles.
- Worst-case load-to-display latency: 3·`REFRESH_DIV` + `DEAD_CYCLES` + 1 cycles. Best case (load on the boundary edge): `DEAD_CYCLES`+1.
- `bcd_load` held high: captures every cycle; `disp` takes the value present on the boundary edge.
- `blank_lz` is sampled combinationally into the output register, so a change takes effect in the next cycle, mid-frame allowed.
- `rst` asserted mid-slot: all outputs go blank immediately (asynchronous) and any pending load is discarded.
- When `DEAD_CYCLES`=0, anodes are never all off except at reset.

## Structure
- Package `seven_seg_pkg`:
  - `NUM_DIGITS`=3.
  - Glyph constants `SEG_0`..`SEG_9`, `SEG_DASH`, `SEG_OFF`.
  - Digit-index type.
- Sub-module `bcd_digit_to_seg`: combinational nibble→active-low glyph, including dash for >9.
- The top holds the prescaler, index counter, `pend`/`disp` registers, blanking logic and output registers.

## Test plan
Bench runs with `REFRESH_DIV`=4, `DEAD_CYCLES`=1.

- Reset release, no load → every slot shows `an_n`=110/101/011 with `seg_n`=1000000 after 1 dead cycle each; `frame_start` every 12 cycles.
- Load 0x123 mid-frame → old value until the next `frame_start`. Then ones slot `seg_n`=0110000, tens 0100100, hundreds 1111001.
- `blank_lz`=1, load 0x005 → hundreds and tens slots show `seg_n`=1111111 with anode still low. Ones shows 0010010.
- `blank_lz`=1, load 0x0A0 → tens shows dash 0111111, hundreds blank, ones shows 1000000.
- Loads of 0x111 then 0x777 within one frame, then 0x999 exactly on the boundary edge → display shows 999 from that boundary and never shows 111 or 777.
- Assert `rst` while the tens slot is active → same cycle `an_n`=111, `seg_n`=1111111. After release, `disp`=000 and the pending load is lost.
